// File: rtl/bms_pkg.sv
// ----------------------------------------------------------------------------
// bms_pkg
// Shared definitions for the BMS current-allocation sequencer:
//   - FSM state encoding
//   - IEEE-754 single-precision field positions and constants
//   - default datapath latency
//   - small field-extraction helpers used by the operand classifier
// ----------------------------------------------------------------------------
package bms_pkg;

    // Sequencer states: accept a request, wait out the datapath latency,
    // then present the captured result until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // IEEE-754 single-precision field layout
    localparam int          FP_SIGN    = 31;
    localparam int          FP_EXP_MSB = 30;
    localparam int          FP_EXP_LSB = 23;
    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

    // All-ones exponent marks Inf or NaN
    localparam logic [FP_EXP_MSB-FP_EXP_LSB:0] FP_EXP_MAX = '1;

    // Cycles from datapath operands stable to datapath results valid
    localparam int LATENCY_DEFAULT = 4;

    // Width of the latency down-counter
    localparam int CNT_W = 4;

    // Exponent field of a single-precision word
    function automatic logic [FP_EXP_MSB-FP_EXP_LSB:0] fp_exp(input logic [31:0] x);
        return x[FP_EXP_MSB:FP_EXP_LSB];
    endfunction

    // Magnitude (everything but the sign); zero for both +0 and -0
    function automatic logic [FP_EXP_MSB:0] fp_mag(input logic [31:0] x);
        return x[FP_EXP_MSB:0];
    endfunction

endpackage : bms_pkg

// File: rtl/bms_alloc_seq_fp_class.sv
// ----------------------------------------------------------------------------
// fp_class
// Combinational classifier for one IEEE-754 single-precision word.
//
// Ports:
//   din          in  32  operand to classify
//   is_zero      out 1   magnitude is zero (+0 or -0)
//   is_neg       out 1   sign bit set (includes -0)
//   is_nonfinite out 1   exponent all ones (Inf or NaN)
// ----------------------------------------------------------------------------
module fp_class
    import bms_pkg::*;
(
    input  logic [31:0] din,
    output logic        is_zero,
    output logic        is_neg,
    output logic        is_nonfinite
);

    assign is_zero      = (fp_mag(din) == '0);
    assign is_neg       = din[FP_SIGN];
    assign is_nonfinite = (fp_exp(din) == FP_EXP_MAX);

endmodule : fp_class

// File: rtl/bms_alloc_seq.sv
// ----------------------------------------------------------------------------
// bms_alloc_seq
// Sequencer wrapped around an external multi-cycle current-split datapath.
// A request from the SOC estimator (four cell SOCs plus pack current) is
// captured and held as the datapath operands together with the mode bits
// (sel: 0 = SOC-proportional/discharge, 1 = reciprocal/charge; eqz: force
// zero). After the datapath latency the four per-cell results are captured
// and presented with a valid/ready handshake. Invalid operands (Inf/NaN, or
// a negative nonzero SOC) flag res_err and force the captured results to 0.
//
// Parameters:
//   LATENCY   datapath latency in cycles, 1..15
//
// Ports:
//   clk                 in  1   clock, rising edge
//   rst_n               in  1   asynchronous active-low reset
//   req_valid/req_ready in/out  request handshake
//   soc_in1..soc_in4    in  32  cell SOC (single precision)
//   i_pack              in  32  pack current (single, positive = discharge)
//   soc1..soc4, I       out 32  held datapath operands
//   sel, eqz            out 1   datapath mode / force-zero
//   I1..I4              in  32  datapath results
//   res_valid/res_ready out/in  result handshake
//   i_cell1..i_cell4    out 32  captured per-cell currents
//   res_err             out 1   invalid operand flag
// ----------------------------------------------------------------------------
module bms_alloc_seq
    import bms_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] soc_in1,
    input  logic [31:0] soc_in2,
    input  logic [31:0] soc_in3,
    input  logic [31:0] soc_in4,
    input  logic [31:0] i_pack,

    output logic [31:0] soc1,
    output logic [31:0] soc2,
    output logic [31:0] soc3,
    output logic [31:0] soc4,
    output logic [31:0] I,
    output logic        sel,
    output logic        eqz,
    input  logic [31:0] I1,
    input  logic [31:0] I2,
    input  logic [31:0] I3,
    input  logic [31:0] I4,

    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] i_cell1,
    output logic [31:0] i_cell2,
    output logic [31:0] i_cell3,
    output logic [31:0] i_cell4,
    output logic        res_err
);

    localparam int              NCELL    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    // ------------------------------------------------------------------
    // Array views of the per-cell ports
    // ------------------------------------------------------------------
    logic [31:0] soc_in_arr [NCELL];
    logic [31:0] dp_arr     [NCELL];

    assign soc_in_arr[0] = soc_in1;
    assign soc_in_arr[1] = soc_in2;
    assign soc_in_arr[2] = soc_in3;
    assign soc_in_arr[3] = soc_in4;

    assign dp_arr[0] = I1;
    assign dp_arr[1] = I2;
    assign dp_arr[2] = I3;
    assign dp_arr[3] = I4;

    // ------------------------------------------------------------------
    // Operand classification (four SOCs + pack current)
    // ------------------------------------------------------------------
    logic [NCELL-1:0] soc_zero;
    logic [NCELL-1:0] soc_neg;
    logic [NCELL-1:0] soc_nonfinite;
    logic [NCELL-1:0] soc_bad;

    generate
        for (genvar gi = 0; gi < NCELL; gi++) begin : g_soc_class
            fp_class u_soc_class (
                .din          (soc_in_arr[gi]),
                .is_zero      (soc_zero[gi]),
                .is_neg       (soc_neg[gi]),
                .is_nonfinite (soc_nonfinite[gi])
            );
            // -0 is an acceptable SOC; any other negative value is not
            assign soc_bad[gi] = soc_nonfinite[gi] | (soc_neg[gi] & ~soc_zero[gi]);
        end
    endgenerate

    logic pack_zero;
    logic pack_neg;
    logic pack_nonfinite;

    fp_class u_pack_class (
        .din          (i_pack),
        .is_zero      (pack_zero),
        .is_neg       (pack_neg),
        .is_nonfinite (pack_nonfinite)
    );

    logic sel_next;
    logic eqz_next;
    logic err_next;

    // -0 must select the discharge mode like +0, so the sign is masked
    assign sel_next = pack_neg & ~pack_zero;
    assign eqz_next = pack_zero;
    assign err_next = (|soc_bad) | pack_nonfinite;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             cnt_zero_reg;
    logic             req_ready_reg;
    logic             res_valid_reg;
    logic             res_err_reg;
    logic             sel_reg;
    logic             eqz_reg;
    logic [31:0]      soc_reg  [NCELL];
    logic [31:0]      i_reg;
    logic [31:0]      cell_reg [NCELL];

    // The terminal-count compare is registered (cnt_zero_reg) so the capture
    // enable comes straight from a flop; this places the capture edge at
    // accept + LATENCY + 1, one edge after the datapath results are valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            cnt_zero_reg  <= 1'b0;
            req_ready_reg <= 1'b0;
            res_valid_reg <= 1'b0;
            res_err_reg   <= 1'b0;
            sel_reg       <= 1'b0;
            eqz_reg       <= 1'b1;
            i_reg         <= FP_ZERO;
            for (int i = 0; i < NCELL; i++) begin
                soc_reg[i]  <= FP_ZERO;
                cell_reg[i] <= FP_ZERO;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_ready_reg && req_valid) begin
                        for (int i = 0; i < NCELL; i++) begin
                            soc_reg[i] <= soc_in_arr[i];
                        end
                        i_reg         <= i_pack;
                        sel_reg       <= sel_next;
                        eqz_reg       <= eqz_next;
                        res_err_reg   <= err_next;
                        cnt_reg       <= CNT_LOAD;
                        cnt_zero_reg  <= 1'b0;
                        req_ready_reg <= 1'b0;
                        state_reg     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    cnt_zero_reg <= (cnt_reg == '0);
                    // Saturating decrement: the counter rests at zero
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                    if (cnt_zero_reg) begin
                        for (int i = 0; i < NCELL; i++) begin
                            cell_reg[i] <= res_err_reg ? FP_ZERO : dp_arr[i];
                        end
                        res_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Ready is raised on the handshake edge, so the earliest
                    // new accept is the following edge.
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b0;
                    res_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = req_ready_reg;
    assign res_valid = res_valid_reg;
    assign res_err   = res_err_reg;
    assign sel       = sel_reg;
    assign eqz       = eqz_reg;
    assign I         = i_reg;

    assign soc1 = soc_reg[0];
    assign soc2 = soc_reg[1];
    assign soc3 = soc_reg[2];
    assign soc4 = soc_reg[3];

    assign i_cell1 = cell_reg[0];
    assign i_cell2 = cell_reg[1];
    assign i_cell3 = cell_reg[2];
    assign i_cell4 = cell_reg[3];

endmodule : bms_alloc_seq

// File: tb/tb_bms_alloc_seq.sv
// ----------------------------------------------------------------------------
// tb_bms_alloc_seq
// Table-driven check of bms_alloc_seq with LATENCY = 4, followed by
// hand-written sequences for capture timing, backpressure, reset during a
// pending request and back-to-back throughput.
// ----------------------------------------------------------------------------
module tb_bms_alloc_seq;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] soc_in1, soc_in2, soc_in3, soc_in4, i_pack;
    logic [31:0] soc1, soc2, soc3, soc4, I;
    logic        sel, eqz;
    logic [31:0] I1, I2, I3, I4;
    logic        res_valid, res_ready;
    logic [31:0] i_cell1, i_cell2, i_cell3, i_cell4;
    logic        res_err;

    always #5 clk = ~clk;

    bms_alloc_seq #(.LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .soc_in1   (soc_in1),
        .soc_in2   (soc_in2),
        .soc_in3   (soc_in3),
        .soc_in4   (soc_in4),
        .i_pack    (i_pack),
        .soc1      (soc1),
        .soc2      (soc2),
        .soc3      (soc3),
        .soc4      (soc4),
        .I         (I),
        .sel       (sel),
        .eqz       (eqz),
        .I1        (I1),
        .I2        (I2),
        .I3        (I3),
        .I4        (I4),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .i_cell1   (i_cell1),
        .i_cell2   (i_cell2),
        .i_cell3   (i_cell3),
        .i_cell4   (i_cell4),
        .res_err   (res_err)
    );

    typedef struct packed {
        logic [3:0][31:0] soc;
        logic [31:0]      pack;
        logic [3:0][31:0] dp;
        logic             sel;
        logic             eqz;
        logic             err;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] s3, input logic [31:0] s4,
                           input logic [31:0] pk,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] d3, input logic [31:0] d4,
                           input logic sl, input logic ez, input logic er);
        vecs[idx].soc[0] = s1; vecs[idx].soc[1] = s2;
        vecs[idx].soc[2] = s3; vecs[idx].soc[3] = s4;
        vecs[idx].pack   = pk;
        vecs[idx].dp[0]  = d1; vecs[idx].dp[1] = d2;
        vecs[idx].dp[2]  = d3; vecs[idx].dp[3] = d4;
        vecs[idx].sel    = sl;
        vecs[idx].eqz    = ez;
        vecs[idx].err    = er;
    endtask

    task automatic drive_ops(input vec_t v);
        soc_in1 = v.soc[0]; soc_in2 = v.soc[1];
        soc_in3 = v.soc[2]; soc_in4 = v.soc[3];
        i_pack  = v.pack;
    endtask

    task automatic drive_dp(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        I1 = a; I2 = b; I3 = c; I4 = d;
    endtask

    // Called at a negedge; returns at a negedge with req_ready high or
    // records a timeout.
    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (k >= 30) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          k;
        logic [31:0] exp_cell [4];
        v = vecs[idx];
        for (int i = 0; i < 4; i++) exp_cell[i] = v.err ? 32'h0 : v.dp[i];

        wait_ready("vec");
        drive_ops(v);
        drive_dp(v.dp[0], v.dp[1], v.dp[2], v.dp[3]);
        req_valid = 1'b1;
        @(posedge clk);            // accept edge N
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (res_valid !== 1'b1 && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("latency",  32'(k),   32'(LAT + 1));
        chk("soc1",     soc1,     v.soc[0]);
        chk("soc2",     soc2,     v.soc[1]);
        chk("soc3",     soc3,     v.soc[2]);
        chk("soc4",     soc4,     v.soc[3]);
        chk("I",        I,        v.pack);
        chk("sel",      32'(sel), 32'(v.sel));
        chk("eqz",      32'(eqz), 32'(v.eqz));
        chk("res_err",  32'(res_err), 32'(v.err));
        chk("i_cell1",  i_cell1,  exp_cell[0]);
        chk("i_cell2",  i_cell2,  exp_cell[1]);
        chk("i_cell3",  i_cell3,  exp_cell[2]);
        chk("i_cell4",  i_cell4,  exp_cell[3]);
        chk("ready_in_done", 32'(req_ready), 32'd0);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_after_hs", 32'(res_valid), 32'd0);
        chk("ready_after_hs", 32'(req_ready), 32'd1);
        $display("txn %0d: pack=%h sel=%0b eqz=%0b err=%0b latency=%0d cells=%h %h %h %h",
                 idx, v.pack, sel, eqz, res_err, k, i_cell1, i_cell2, i_cell3, i_cell4);
    endtask

    initial begin
        int          k;
        logic [31:0] cap;
        int          acc_cyc [$];
        logic        got_one;

        // ------------------------------------------------------------
        // Vector table: SOCs, pack current, datapath results, expected
        // sel / eqz / res_err
        // ------------------------------------------------------------
        // discharge 5.0 A, equal SOCs
        set_vec(0, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h40A00000,
                   32'h3FA00000, 32'h3FA00001, 32'h3FA00002, 32'h3FA00003, 1'b0, 1'b0, 1'b0);
        // charge -5.0 A, mixed SOCs
        set_vec(1, 32'h3F000000, 32'h3F4CCCCD, 32'h3E4CCCCD, 32'h3F800000, 32'hC0A00000,
                   32'hBF800000, 32'hBF900000, 32'hBFA00000, 32'hBFB00000, 1'b1, 1'b0, 1'b0);
        // -0 pack current
        set_vec(2, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h80000000,
                   32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b1, 1'b0);
        // +0 pack current
        set_vec(3, 32'h3E800000, 32'h3F000000, 32'h3F400000, 32'h3F800000, 32'h00000000,
                   32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 1'b0, 1'b1, 1'b0);
        // NaN SOC2
        set_vec(4, 32'h3F000000, 32'h7FC00000, 32'h3F000000, 32'h3F000000, 32'h40A00000,
                   32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b1);
        // negative SOC4
        set_vec(5, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'hBF000000, 32'h40A00000,
                   32'hDEADBEEF, 32'hCAFEF00D, 32'h01020304, 32'h0A0B0C0D, 1'b0, 1'b0, 1'b1);
        // -0 SOC3 is acceptable
        set_vec(6, 32'h3F000000, 32'h3F000000, 32'h80000000, 32'h3F000000, 32'hC0A00000,
                   32'hBF000000, 32'hBF100000, 32'h80000000, 32'hBF200000, 1'b1, 1'b0, 1'b0);
        // +Inf pack current
        set_vec(7, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h7F800000,
                   32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b1);
        // -Inf pack current
        set_vec(8, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'hFF800000,
                   32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 1'b1);

        // ------------------------------------------------------------
        // Reset state
        // ------------------------------------------------------------
        rst_n     = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        soc_in1 = '0; soc_in2 = '0; soc_in3 = '0; soc_in4 = '0; i_pack = '0;
        drive_dp('0, '0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_eqz",       32'(eqz),       32'd1);
        chk("rst_sel",       32'(sel),       32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
        chk("rst_I",         I,              32'h0);
        chk("rst_soc1",      soc1,           32'h0);
        chk("rst_i_cell1",   i_cell1,        32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready), 32'd1);

        // ------------------------------------------------------------
        // Table-driven transactions
        // ------------------------------------------------------------
        for (int v = 0; v < NVEC; v++) run_vec(v);

        // ------------------------------------------------------------
        // Capture timing: datapath results are garbage until the cycle
        // before the capture edge (accept + LATENCY + 1)
        // ------------------------------------------------------------
        wait_ready("cap");
        drive_ops(vecs[0]);
        drive_dp(32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int j = 1; j <= LAT; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk("cap_early_valid", 32'(res_valid), 32'd0);
        end
        drive_dp(32'h40000001, 32'h40000002, 32'h40000003, 32'h40000004);
        @(posedge clk);
        @(negedge clk);
        chk("cap_valid",   32'(res_valid), 32'd1);
        chk("cap_i_cell1", i_cell1, 32'h40000001);
        chk("cap_i_cell4", i_cell4, 32'h40000004);
        drive_dp(32'hBBBBBBBB, 32'hBBBBBBBB, 32'hBBBBBBBB, 32'hBBBBBBBB);
        $display("txn cap: cells=%h %h %h %h", i_cell1, i_cell2, i_cell3, i_cell4);

        // ------------------------------------------------------------
        // Backpressure: 10 cycles in DONE with req_valid pulses ignored
        // ------------------------------------------------------------
        for (int j = 0; j < 10; j++) begin
            req_valid = j[0];
            soc_in1   = 32'h3F700000 + 32'(j);
            i_pack    = 32'hC1000000;
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid",   32'(res_valid), 32'd1);
            chk("bp_ready",   32'(req_ready), 32'd0);
            chk("bp_i_cell1", i_cell1, 32'h40000001);
            chk("bp_i_cell3", i_cell3, 32'h40000003);
            chk("bp_soc1",    soc1,    vecs[0].soc[0]);
            chk("bp_I",       I,       vecs[0].pack);
            chk("bp_res_err", 32'(res_err), 32'd0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_hs_valid", 32'(res_valid), 32'd0);
        chk("bp_hs_ready", 32'(req_ready), 32'd1);
        chk("bp_no_capture", I, vecs[0].pack);
        $display("txn backpressure: released, req_ready=%0b", req_ready);

        // ------------------------------------------------------------
        // Reset two cycles after accept: immediate clear, no result
        // ------------------------------------------------------------
        wait_ready("rst");
        drive_ops(vecs[1]);
        drive_dp(vecs[1].dp[0], vecs[1].dp[1], vecs[1].dp[2], vecs[1].dp[3]);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_soc1",    soc1,           32'h0);
        chk("mid_rst_I",       I,              32'h0);
        chk("mid_rst_sel",     32'(sel),       32'd0);
        chk("mid_rst_eqz",     32'(eqz),       32'd1);
        chk("mid_rst_ready",   32'(req_ready), 32'd0);
        chk("mid_rst_valid",   32'(res_valid), 32'd0);
        chk("mid_rst_i_cell1", i_cell1,        32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int j = 0; j < LAT + 8; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (res_valid === 1'b1) k++;
        end
        chk("post_rst_no_valid", 32'(k), 32'd0);
        $display("txn reset: pending request discarded, res_valid seen %0d times", k);

        // ------------------------------------------------------------
        // Back-to-back: req_valid and res_ready held high, soc_in1
        // changing every cycle
        // ------------------------------------------------------------
        drive_ops(vecs[0]);
        drive_dp(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        req_valid = 1'b1;
        res_ready = 1'b1;
        got_one   = 1'b0;
        cap       = '0;
        for (int c = 0; c < 34; c++) begin
            soc_in1 = 32'h3F000000 + 32'(c);
            if (got_one) chk("b2b_soc1_held", soc1, cap);
            if (req_ready === 1'b1) begin
                acc_cyc.push_back(c);
                cap     = soc_in1;
                got_one = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        res_ready = 1'b0;
        chk("b2b_accept_count", 32'(acc_cyc.size()), 32'd5);
        for (int j = 1; j < acc_cyc.size(); j++) begin
            chk("b2b_interval", 32'(acc_cyc[j] - acc_cyc[j-1]), 32'(LAT + 3));
        end
        $display("txn back-to-back: %0d accepts", acc_cyc.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule : tb_bms_alloc_seq

// File: doc/bms_alloc_seq.md
BMS_ALLOC_SEQ -- requirements
Module: bms_alloc_seq

Interface
REQ-001 Parameter: LATENCY, default 4, cycles from datapath inputs stable to I1..I4 valid; legal range 1..15.
REQ-002 Port: clk  in  1  single clock, all logic on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  in  1  request from SOC estimator; req_ready  out  1  block can accept.
REQ-005 Port: soc_in1..soc_in4  in  32 each  cell SOC, IEEE-754 single; i_pack  in  32  pack current, IEEE-754 single (positive = discharge).
REQ-006 Port: soc1..soc4  out  32 each, I  out  32  held operands to the current-split datapath.
REQ-007 Port: sel  out  1  datapath mode (0 = SOC-proportional/discharge, 1 = reciprocal/charge); eqz  out  1  force-zero outputs.
REQ-008 Port: I1..I4  in  32 each  datapath results.
REQ-009 Port: res_valid  out  1, res_ready  in  1  result handshake; i_cell1..i_cell4  out  32 each  captured results; res_err  out  1  invalid operand flag.

Function
REQ-010 FSM states: IDLE, WAIT, DONE; encoding in shared package.
REQ-011 IDLE: req_ready=1; on req_valid=1, register soc_in1..4 and i_pack into soc1..4 and I, register sel/eqz/res_err, load counter with LATENCY-1, go to WAIT.
REQ-012 sel = i_pack[31] (sign) when i_pack is nonzero; sel = 0 when zero.
REQ-013 i_pack zero: bits[30:0] all 0 (both signed zeros); sets eqz=1; otherwise eqz=0.
REQ-014 res_err = 1 when any captured operand has exponent 8'hFF (Inf/NaN) or any SOC has sign bit 1 and bits[30:0] nonzero; otherwise 0.
REQ-015 soc1..4, I, sel, eqz held constant from capture until next accepted request.
REQ-016 WAIT: req_ready=0; counter decrements each cycle; at counter 0, capture I1..I4 into i_cell1..4, go to DONE.
REQ-017 Latency: request accepted at edge N -> res_valid=1 after edge N+LATENCY+1.
REQ-018 Capture when res_err=1: i_cell1..4 forced to 32'h00000000 regardless of I1..I4.
REQ-019 DONE: res_valid=1, req_ready=0; i_cell1..4 and res_err stable until res_ready=1; on res_valid&&res_ready, go to IDLE.
REQ-020 req_valid in WAIT/DONE ignored (not captured); upstream holds request until req_ready.
REQ-021 No new request accepted in the same cycle as result handshake; earliest acceptance is the cycle after returning to IDLE.
REQ-022 Counter width 4 bits; no wrap-around: decrement stops at 0.

Reset
REQ-023 rst_n=0 asynchronously: state=IDLE, counter=0, req_ready=0 while asserted, 1 in first cycle after release.
REQ-024 Reset values: soc1..4, I, i_cell1..4 = 32'h00000000; sel=0; eqz=1; res_valid=0; res_err=0.
REQ-025 Reset mid-WAIT or mid-DONE: pending result discarded, no res_valid emitted.

Structure
REQ-026 Shared package bms_pkg: state enum, FP_EXP_MSB=30, FP_EXP_LSB=23, FP_SIGN=31, FP_ZERO=32'h0, LATENCY default constant.
REQ-027 One sub-module fp_class: combinational, 32-bit in -> is_zero, is_neg, is_nonfinite; instantiated five times (four SOC, one pack current).

Verification
REQ-028 Discharge: i_pack=32'h40A00000 (5.0), SOCs 0.5/0.5/0.5/0.5 -> sel=0, eqz=0, res_valid exactly LATENCY+1 cycles after accept, i_cell = I1..I4 sampled at capture.
REQ-029 Charge: i_pack=32'hC0A00000 (-5.0) -> sel=1, eqz=0; zero: i_pack=32'h80000000 -> sel=0, eqz=1.
REQ-030 Error: soc_in2=32'h7FC00000 (NaN) -> res_err=1, i_cell1..4=0 regardless of I inputs.
REQ-031 Backpressure: res_ready=0 for 10 cycles in DONE -> outputs stable, req_ready=0, req_valid pulses ignored; res_ready=1 -> IDLE next cycle.
REQ-032 Reset: assert rst_n=0 two cycles after accept -> all outputs at reset values immediately, no res_valid after release.
REQ-033 Back-to-back: req_valid held high, res_ready held high -> one request per LATENCY+3 cycles, operands never change during WAIT.
